ped_button_conditioner: RTL and testbench

//   Upstream stage of the traffic-light controller. Conditions the raw pedestrian call

---
 rtl/ped_button_conditioner_if.sv | 23 ++
 rtl/ped_button_conditioner.sv | 128 ++++++++++++
 tb/tb_ped_button_conditioner.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ped_button_conditioner_if.sv
// Pedestrian button conditioner signal bundle: raw button and controller status in,
// request, lamp, debounced level and press statistics out.
interface ped_button_conditioner_if #(
  parameter int unsigned CNT_W = 8
);
  logic             btn_raw;
  logic             ped_active;
  logic             ped_req;
  logic             ped_wait;
  logic             btn_clean;
  logic [CNT_W-1:0] accept_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output btn_raw, ped_active,
    input  ped_req, ped_wait, btn_clean, accept_cnt, drop_cnt
  );

  modport slave (
    input  btn_raw, ped_active,
    output ped_req, ped_wait, btn_clean, accept_cnt, drop_cnt
  );
endinterface

// File: rtl/ped_button_conditioner.sv
// Pedestrian call button front end: synchronise, debounce and edge-detect the button,
// then hold a request for the light controller until served, with a post-crossing lockout.
module ped_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8,
  parameter int unsigned CNT_W           = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  ped_button_conditioner_if.slave bus
);

  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LCNT_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [LCNT_W-1:0] lcnt, lcnt_nxt;
  logic [DCNT_W-1:0] dcnt;
  logic              s1, s2;
  logic              btn_clean_q, btn_clean_d;
  logic              press;
  logic              acc_inc, drop_inc;
  logic              ped_req_q, ped_wait_q;
  logic [CNT_W-1:0]  accept_q, drop_q;

  // Two-flop synchroniser, debounce filter and release-insensitive press detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      btn_clean_q <= 1'b0;
      btn_clean_d <= 1'b0;
      dcnt        <= '0;
    end else begin
      s1          <= bus.btn_raw;
      s2          <= s1;
      btn_clean_d <= btn_clean_q;
      if (s2 == btn_clean_q) begin
        dcnt <= '0;
      end else if (dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_clean_q <= s2;
        dcnt        <= '0;
      end else begin
        dcnt <= dcnt + DCNT_W'(1);
      end
    end
  end

  assign press = btn_clean_q & ~btn_clean_d;

  // Request FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lcnt  <= '0;
    end else begin
      state <= state_nxt;
      lcnt  <= lcnt_nxt;
    end
  end

  // Next state and press accounting; every press outside an open IDLE slot is a drop
  always_comb begin
    state_nxt = state;
    lcnt_nxt  = lcnt;
    acc_inc   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          if (bus.ped_active) begin
            drop_inc = 1'b1;
          end else begin
            acc_inc   = 1'b1;
            state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        drop_inc = press;
        if (bus.ped_active) state_nxt = SERVING;
      end
      SERVING: begin
        drop_inc = press;
        if (!bus.ped_active) begin
          state_nxt = LOCKOUT;
          lcnt_nxt  = LCNT_W'(LOCKOUT_CYCLES - 1);
        end
      end
      LOCKOUT: begin
        drop_inc = press;
        if (lcnt == '0) state_nxt = IDLE;
        else            lcnt_nxt  = lcnt - LCNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered Moore outputs and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_req_q  <= 1'b0;
      ped_wait_q <= 1'b0;
      accept_q   <= '0;
      drop_q     <= '0;
    end else begin
      ped_req_q  <= (state_nxt == PENDING);
      ped_wait_q <= (state_nxt == PENDING);
      if (acc_inc && (accept_q != CNT_MAX)) accept_q <= accept_q + CNT_W'(1);
      if (drop_inc && (drop_q != CNT_MAX))  drop_q   <= drop_q + CNT_W'(1);
    end
  end

  assign bus.ped_req    = ped_req_q;
  assign bus.ped_wait   = ped_wait_q;
  assign bus.btn_clean  = btn_clean_q;
  assign bus.accept_cnt = accept_q;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Bench for ped_button_conditioner: two instances (8-bit and 2-bit counters) share
// directed stimulus and are compared every cycle against a timeline-based model.
module tb_ped_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned L = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_raw = 1'b0;
  logic ped_active = 1'b0;
  bit   cmp_en = 1'b0;

  int passed = 0;
  int total  = 0;

  ped_button_conditioner_if #(.CNT_W(8)) bus8 ();
  ped_button_conditioner_if #(.CNT_W(2)) bus2 ();

  assign bus8.btn_raw    = btn_raw;
  assign bus8.ped_active = ped_active;
  assign bus2.btn_raw    = btn_raw;
  assign bus2.ped_active = ped_active;

  ped_button_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );
  ped_button_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint sat(input int v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : longint'(v);
  endfunction

  // Model: request life cycle as phases on an absolute edge timeline
  typedef enum int {P_IDLE, P_WAIT, P_CROSS, P_COOL} phase_t;
  phase_t ph = P_IDLE;
  longint edge_no = 0;
  longint cool_end = 0;
  bit     m_s1 = 0, m_s2 = 0, m_clean = 0, m_clean_prev = 0;
  int     differ_run = 0;
  int     acc = 0, drp = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_IDLE; edge_no = 0; cool_end = 0;
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_clean_prev = 0;
      differ_run = 0; acc = 0; drp = 0;
    end else begin : step
      bit press;
      edge_no++;
      press = m_clean && !m_clean_prev;
      case (ph)
        P_IDLE:  if (press) begin
                   if (ped_active) drp++;
                   else begin acc++; ph = P_WAIT; end
                 end
        P_WAIT:  begin if (press) drp++; if (ped_active) ph = P_CROSS; end
        P_CROSS: begin
                   if (press) drp++;
                   if (!ped_active) begin ph = P_COOL; cool_end = edge_no + L; end
                 end
        default: begin if (press) drp++; if (edge_no == cool_end) ph = P_IDLE; end
      endcase
      m_clean_prev = m_clean;
      // Level is adopted once it has disagreed on D consecutive edges
      if (m_s2 != m_clean) begin
        differ_run++;
        if (differ_run == D) begin m_clean = m_s2; differ_run = 0; end
      end else differ_run = 0;
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("u8.ped_req",    bus8.ped_req,    ph == P_WAIT);
      check("u8.ped_wait",   bus8.ped_wait,   ph == P_WAIT);
      check("u8.btn_clean",  bus8.btn_clean,  m_clean);
      check("u8.accept_cnt", bus8.accept_cnt, sat(acc, 8));
      check("u8.drop_cnt",   bus8.drop_cnt,   sat(drp, 8));
      check("u2.ped_req",    bus2.ped_req,    ph == P_WAIT);
      check("u2.accept_cnt", bus2.accept_cnt, sat(acc, 2));
      check("u2.drop_cnt",   bus2.drop_cnt,   sat(drp, 2));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic press_serve();
    btn_raw = 1'b1; tick(8);
    btn_raw = 1'b0; tick(8);
    ped_active = 1'b1; tick(3);
    ped_active = 1'b0; tick(12);
  endtask

  initial begin
    @(negedge clk);
    #1;
    check("reset ped_req",    bus8.ped_req,    0);
    check("reset ped_wait",   bus8.ped_wait,   0);
    check("reset btn_clean",  bus8.btn_clean,  0);
    check("reset accept_cnt", bus8.accept_cnt, 0);
    check("reset drop_cnt",   bus8.drop_cnt,   0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Bounce shorter than the debounce window
    for (int i = 0; i < 6; i++) begin
      btn_raw = (i % 2 == 0);
      tick(1);
    end
    btn_raw = 1'b0;
    tick(10);
    check("bounce btn_clean", bus8.btn_clean, 0);
    check("bounce ped_req",   bus8.ped_req,   0);
    check("bounce accept",    bus8.accept_cnt, 0);
    check("bounce drop",      bus8.drop_cnt,   0);

    // Clean press: first sampled at edge 1
    btn_raw = 1'b1;
    tick(5);
    check("t1 btn_clean e5", bus8.btn_clean, 0);
    tick(1);
    check("t1 btn_clean e6", bus8.btn_clean, 1);
    check("t1 ped_req e6",   bus8.ped_req,   0);
    tick(1);
    check("t1 ped_req e7",   bus8.ped_req,    1);
    check("t1 ped_wait e7",  bus8.ped_wait,   1);
    check("t1 accept e7",    bus8.accept_cnt, 1);
    tick(13);
    btn_raw = 1'b0;
    tick(10);
    check("t1 release no event", bus8.ped_req, 1);

    // Service with presses landing in SERVING (edge 7) and LOCKOUT (edge 20)
    ped_active = 1'b1; btn_raw = 1'b1;
    tick(1);
    check("t3 ped_req drop", bus8.ped_req, 0);
    tick(5);
    btn_raw = 1'b0;
    tick(1);
    check("t4 drop serving", bus8.drop_cnt, 1);
    tick(6);
    btn_raw = 1'b1;
    tick(2);
    ped_active = 1'b0;
    tick(4);
    btn_raw = 1'b0;
    tick(1);
    check("t4 drop lockout", bus8.drop_cnt, 2);
    check("t4 ped_req low",  bus8.ped_req,  0);
    tick(4);
    tick(2);
    btn_raw = 1'b1;
    tick(6);
    check("t4 ped_req e32", bus8.ped_req, 0);
    tick(1);
    check("t4 ped_req e33", bus8.ped_req,    1);
    check("t4 accept",      bus8.accept_cnt, 2);
    btn_raw = 1'b0;
    tick(10);
    ped_active = 1'b1; tick(3);
    ped_active = 1'b0; tick(12);

    // Saturation of the 2-bit instance
    for (int k = 0; k < 3; k++) press_serve();
    check("t5 accept 8b", bus8.accept_cnt, 5);
    check("t5 accept 2b", bus2.accept_cnt, 3);
    check("t5 drop 2b",   bus2.drop_cnt,   2);

    // Reset while a request is pending
    btn_raw = 1'b1; tick(8);
    btn_raw = 1'b0; tick(8);
    check("t6 pending", bus8.ped_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async ped_req",  bus8.ped_req,  0);
    check("t6 async ped_wait", bus8.ped_wait, 0);
    check("t6 async 2b req",   bus2.ped_req,  0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t6 accept cleared", bus8.accept_cnt, 0);
    check("t6 drop cleared",   bus8.drop_cnt,   0);
    tick(12);
    check("t6 no replay", bus8.ped_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
